// File: rtl/bootram_ctrl.sv
// Arbiter/sequencer between the picorv32 native bus, a byte-stream loader and four 2Kx8 SP boot RAM lanes.
// Optional loader checksum is enabled by defining BOOTRAM_LDSUM_EN.
module bootram_ctrl #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_valid,
  input  logic [ADDR_W+1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  output logic              cpu_ready,
  output logic [31:0]       cpu_rdata,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic [ADDR_W+1:0] ld_count,
  output logic [7:0]        ld_sum,
  output logic              ram_ce,
  output logic [3:0]        ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  typedef enum logic [2:0] {IDLE, CPU_WR, CPU_RD, RD_CAP, CPU_ACK, LD_WR} state_t;

  localparam logic [ADDR_W+1:0] PTR_ONE = {{(ADDR_W+1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic              ram_ce_q, ram_ce_d;
  logic [3:0]        ram_wre_q, ram_wre_d;
  logic [ADDR_W-1:0] ram_ad_q, ram_ad_d;
  logic [31:0]       ram_din_q, ram_din_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic [ADDR_W+1:0] ptr_q, ptr_d;
  logic [ADDR_W+1:0] ptr_base;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^cpu_addr[1:0];

  // ld_start overrides the pointer in the same cycle, so a coincident byte lands at 0.
  assign ptr_base = ld_start ? '0 : ptr_q;

  always_comb begin
    state_d     = state_q;
    ram_ce_d    = 1'b0;
    ram_wre_d   = 4'b0000;
    ram_ad_d    = ram_ad_q;
    ram_din_d   = ram_din_q;
    cpu_rdata_d = cpu_rdata_q;
    ptr_d       = ptr_base;
    case (state_q)
      IDLE: begin
        if (ld_valid) begin
          state_d   = LD_WR;
          ram_ce_d  = 1'b1;
          ram_ad_d  = ptr_base[ADDR_W+1:2];
          ram_wre_d = 4'b0001 << ptr_base[1:0];
          ram_din_d = {4{ld_data}};
          ptr_d     = ptr_base + PTR_ONE;
        end else if (cpu_valid) begin
          ram_ce_d = 1'b1;
          ram_ad_d = cpu_addr[ADDR_W+1:2];
          if (cpu_wstrb != 4'b0000) begin
            state_d   = CPU_WR;
            ram_wre_d = cpu_wstrb;
            ram_din_d = cpu_wdata;
          end else begin
            state_d = CPU_RD;
          end
        end
      end
      CPU_WR:  state_d = CPU_ACK;
      CPU_RD:  state_d = RD_CAP;
      RD_CAP: begin
        cpu_rdata_d = ram_dout;
        state_d     = CPU_ACK;
      end
      CPU_ACK: state_d = IDLE;
      LD_WR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ram_ce_q    <= 1'b0;
      ram_wre_q   <= 4'b0000;
      ram_ad_q    <= '0;
      ram_din_q   <= '0;
      cpu_rdata_q <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      ram_ce_q    <= ram_ce_d;
      ram_wre_q   <= ram_wre_d;
      ram_ad_q    <= ram_ad_d;
      ram_din_q   <= ram_din_d;
      cpu_rdata_q <= cpu_rdata_d;
      ptr_q       <= ptr_d;
    end
  end

`ifdef BOOTRAM_LDSUM_EN
  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = (ld_start ? 8'h00 : sum_q) +
            (((state_q == IDLE) && ld_valid) ? ld_data : 8'h00);
  end

  always_ff @(posedge clk) begin
    if (reset) sum_q <= 8'h00;
    else       sum_q <= sum_d;
  end

  assign ld_sum = sum_q;
`else
  assign ld_sum = 8'h00;
`endif

  assign cpu_ready = (state_q == CPU_ACK);
  assign cpu_rdata = cpu_rdata_q;
  assign ld_ready  = (state_q == IDLE);
  assign ld_count  = ptr_q;
  assign ram_ce    = ram_ce_q;
  assign ram_wre   = ram_wre_q;
  assign ram_ad    = ram_ad_q;
  assign ram_din   = ram_din_q;

endmodule

// File: tb/tb_bootram_ctrl.sv
// Self-checking bench for bootram_ctrl with a behavioural 4-lane SP RAM and a read-data scoreboard.
module tb_bootram_ctrl;

  localparam int AW = 11;
`ifdef BOOTRAM_LDSUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_valid;
  logic [AW+1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [3:0]    cpu_wstrb;
  logic          cpu_ready;
  logic [31:0]   cpu_rdata;
  logic          ld_start;
  logic          ld_valid;
  logic [7:0]    ld_data;
  logic          ld_ready;
  logic [AW+1:0] ld_count;
  logic [7:0]    ld_sum;
  logic          ram_ce;
  logic [3:0]    ram_wre;
  logic [AW-1:0] ram_ad;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout;

  int checks = 0;
  int errors = 0;

  // Scoreboard entry: {is_read, expected rdata}
  logic [32:0] sb[$];
  logic [32:0] mon_e;

  logic [31:0] mem [0:(1<<AW)-1] = '{default: 32'h0};

  always #5 clk = ~clk;

  bootram_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_count(ld_count), .ld_sum(ld_sum),
    .ram_ce(ram_ce), .ram_wre(ram_wre), .ram_ad(ram_ad),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Single-port RAM lanes, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_ce) begin
      ram_dout <= mem[ram_ad];
      for (int l = 0; l < 4; l++)
        if (ram_wre[l]) mem[ram_ad][8*l +: 8] <= ram_din[8*l +: 8];
    end
  end

  // Completion monitor: every cpu_ready must match a pending transaction.
  always @(negedge clk) begin
    if (!reset && cpu_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: cpu_ready=1 with no pending request at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e[32]) begin
          checks++;
          if (cpu_rdata !== mon_e[31:0]) begin
            errors++;
            $display("FAIL rd_data: got %h expected %h", cpu_rdata, mon_e[31:0]);
          end else
            $display("read ack ok: rdata=%h", cpu_rdata);
        end else
          $display("write ack ok");
      end
    end
  end

  task automatic cpu_write(input logic [AW+1:0] addr, input logic [31:0] data, input logic [3:0] strb);
    sb.push_back({1'b0, 32'h0});
    cpu_addr = addr; cpu_wdata = data; cpu_wstrb = strb; cpu_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ram_ce, ram_wre, ram_ad, ram_din} !== {1'b1, strb, addr[AW+1:2], data}) begin
      errors++;
      $display("FAIL wr_strobe_T1: ce/wre/ad/din=%b/%b/%h/%h expected 1/%b/%h/%h",
               ram_ce, ram_wre, ram_ad, ram_din, strb, addr[AW+1:2], data);
    end
    @(posedge clk); #1;
    checks++;
    if (cpu_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_ready_T2: cpu_ready=%b expected 1", cpu_ready);
    end
    cpu_valid = 1'b0; cpu_wstrb = 4'h0;
    @(posedge clk); #1;
    checks++;
    if ({cpu_ready, ld_ready, ram_ce} !== 3'b010) begin
      errors++;
      $display("FAIL wr_idle_T3: ready/ld_ready/ce=%b expected 010", {cpu_ready, ld_ready, ram_ce});
    end
  endtask

  task automatic cpu_read(input logic [AW+1:0] addr, input logic [31:0] exp_data);
    int lat;
    sb.push_back({1'b1, exp_data});
    cpu_addr = addr; cpu_wstrb = 4'h0; cpu_valid = 1'b1;
    lat = 0;
    while (cpu_ready !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        checks++;
        if ({ram_ce, ram_wre, ram_ad} !== {1'b1, 4'h0, addr[AW+1:2]}) begin
          errors++;
          $display("FAIL rd_ce_T1: ce/wre/ad=%b/%b/%h expected 1/0000/%h",
                   ram_ce, ram_wre, ram_ad, addr[AW+1:2]);
        end
      end
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL rd_latency: cpu_ready after %0d cycles expected 3", lat);
    end
    cpu_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic ld_byte(input logic [7:0] data);
    ld_valid = 1'b1; ld_data = data;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ram_ce, ram_wre, ram_ad, ram_din, cpu_ready, cpu_rdata, ld_count, ld_sum} !== '0 || ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: ce=%b wre=%b ad=%h din=%h rdy=%b rdata=%h cnt=%h sum=%h ld_ready=%b",
               ram_ce, ram_wre, ram_ad, ram_din, cpu_ready, cpu_rdata, ld_count, ld_sum, ld_ready);
    end else
      $display("reset state ok");
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    cpu_write(13'h0010, 32'hDEADBEEF, 4'hF);
    cpu_read(13'h0010, 32'hDEADBEEF);
  endtask

  task automatic test_partial_write;
    cpu_write(13'h0020, 32'h11223344, 4'hF);
    cpu_write(13'h0020, 32'h00AA0000, 4'h4);
    cpu_read(13'h0020, 32'h11AA3344);
  endtask

  task automatic test_loader_stream;
    ld_start = 1'b1;
    @(posedge clk); #1;
    ld_start = 1'b0;
    for (int i = 1; i <= 5; i++) ld_byte(i[7:0]);
    checks++;
    if (ld_count !== 13'd5 || ld_sum !== (SUM_EN ? 8'h0F : 8'h00)) begin
      errors++;
      $display("FAIL ld_stream_count: count=%0d sum=%h expected 5 sum=%h", ld_count, ld_sum,
               SUM_EN ? 8'h0F : 8'h00);
    end else
      $display("loader stream ok: count=%0d sum=%h", ld_count, ld_sum);
    cpu_read(13'h0000, 32'h04030201);
    cpu_read(13'h0004, 32'h00000005);
  endtask

  task automatic test_back_to_back;
    int n;
    sb.push_back({1'b1, 32'h00000605});
    ld_valid = 1'b1; ld_data = 8'h06;
    cpu_valid = 1'b1; cpu_addr = 13'h0004; cpu_wstrb = 4'h0;
    @(posedge clk); #1;
    checks++;
    if ({ram_wre, ram_ad, ram_din, ld_ready, cpu_ready} !== {4'b0010, 11'd1, 32'h06060606, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL arb_loader_first: wre=%b ad=%h din=%h ld_ready=%b rdy=%b expected 0010/001/06060606/0/0",
               ram_wre, ram_ad, ram_din, ld_ready, cpu_ready);
    end
    ld_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({ld_ready, ram_ce, ram_wre} !== {1'b0, 1'b1, 4'h0}) begin
      errors++;
      $display("FAIL arb_cpu_busy: ld_ready=%b ce=%b wre=%b expected 0/1/0000", ld_ready, ram_ce, ram_wre);
    end
    n = 0;
    while (cpu_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL arb_cpu_latency: ready %0d cycles after busy check expected 2", n);
    end
    cpu_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ld_count !== 13'd6) begin
      errors++;
      $display("FAIL arb_count: ld_count=%0d expected 6", ld_count);
    end
  endtask

  task automatic test_start_collision;
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'h77;
    @(posedge clk); #1;
    ld_start = 1'b0; ld_valid = 1'b0;
    checks++;
    if ({ram_ad, ram_wre, ld_count, ld_sum} !== {11'd0, 4'b0001, 13'd1, (SUM_EN ? 8'h77 : 8'h00)}) begin
      errors++;
      $display("FAIL start_collision: ad=%h wre=%b count=%0d sum=%h", ram_ad, ram_wre, ld_count, ld_sum);
    end else
      $display("start+byte ok: count=%0d sum=%h", ld_count, ld_sum);
    @(posedge clk); #1;
    cpu_read(13'h0000, 32'h04030277);
  endtask

  task automatic test_reset_mid;
    cpu_valid = 1'b1; cpu_addr = 13'h0010; cpu_wstrb = 4'h0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    checks++;
    if ({ram_ce, ram_wre, ram_ad, ram_din, cpu_ready, cpu_rdata, ld_count, ld_sum} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: ce=%b wre=%b ad=%h din=%h rdy=%b rdata=%h cnt=%h sum=%h",
               ram_ce, ram_wre, ram_ad, ram_din, cpu_ready, cpu_rdata, ld_count, ld_sum);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (cpu_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_no_ready: cpu_ready=%b expected 0 (cycle %0d)", cpu_ready, i);
      end
    end
    cpu_read(13'h0010, 32'hDEADBEEF);
  endtask

  task automatic test_wrap;
    logic [7:0] exp_sum;
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'h00;
    @(posedge clk); #1;
    ld_start = 1'b0; ld_valid = 1'b0;
    @(posedge clk); #1;
    exp_sum = 8'h00;
    for (int i = 1; i < 8191; i++) begin
      ld_byte(i[7:0]);
      exp_sum = exp_sum + i[7:0];
    end
    checks++;
    if (ld_count !== 13'h1FFF) begin
      errors++;
      $display("FAIL wrap_precount: ld_count=%h expected 1fff", ld_count);
    end
    ld_valid = 1'b1; ld_data = 8'hA5;
    exp_sum = exp_sum + 8'hA5;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    checks++;
    if ({ram_ad, ram_wre, ram_din, ld_count} !== {11'h7FF, 4'b1000, 32'hA5A5A5A5, 13'd0}) begin
      errors++;
      $display("FAIL wrap_write: ad=%h wre=%b din=%h count=%h expected 7ff/1000/a5a5a5a5/0000",
               ram_ad, ram_wre, ram_din, ld_count);
    end else
      $display("wrap write ok: count=%h", ld_count);
    checks++;
    if (ld_sum !== (SUM_EN ? exp_sum : 8'h00)) begin
      errors++;
      $display("FAIL wrap_sum: ld_sum=%h expected %h", ld_sum, SUM_EN ? exp_sum : 8'h00);
    end
    @(posedge clk); #1;
    cpu_read(13'h1FFC, 32'hA5FEFDFC);
  endtask

  initial begin
    reset = 1'b1; cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    test_reset();
    test_write_read();
    test_partial_write();
    test_loader_stream();
    test_back_to_back();
    test_start_collision();
    test_reset_mid();
    test_wrap();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d transactions never completed expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
